haar_stage_accumulator: RTL
===========================

# haar_stage_accumulator

Sequential stage-sum block that sits directly downstream of the Haar feature classifier. For each cascade stage it accepts the per-feature `o_haarvalue` words (left or right leaf value) one per cycle, sums them as signed values with saturation, and compares the total with the stage threshold. It then reports a registered pass/fail verdict to the cascade controller. One evaluation runs at a time, bracketed by a start/done handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of each incoming leaf value, two's complement.
- `SUM_WIDTH`, 16: accumulator and stage-threshold width, two's complement; must be ≥ `DATA_WIDTH`+`COUNT_WIDTH`.
- `COUNT_WIDTH`, 8: width of the per-stage classifier count (max 255 features/stage).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  begin a stage evaluation; sampled only in IDLE.
- `i_num_classifiers`  in  COUNT_WIDTH  number of leaf values in this stage; latched on accepted `i_start`.
- `i_stage_threshold`  in  SUM_WIDTH  signed stage threshold; latched on accepted `i_start`.
- `i_valid`  in  1  `i_haarvalue` holds a leaf value this cycle.
- `i_haarvalue`  in  DATA_WIDTH  signed leaf value from the classifier.
- `o_ready`  out  1  high in ACCUM; a value is accepted when `i_valid && o_ready`.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse; the verdict is valid.
- `o_pass`  out  1  stage verdict; held until the next accepted `i_start`.
- `o_sum`  out  SUM_WIDTH  final saturated stage sum; held with `o_pass`.

## Operation
- FSM states: IDLE, ACCUM, DECIDE, DONE.
- IDLE:
  - `i_start`=1 latches the count and threshold, clears the accumulator and the accepted-count register, and clears `o_pass`/`o_sum`.
  - Next state is ACCUM if count > 0, otherwise DECIDE.
- ACCUM:
  - Each accepted value is sign-extended to SUM_WIDTH and added to the accumulator, and the accepted count increments.
  - When the accepted count reaches `i_num_classifiers`, the FSM moves to DECIDE.
  - `i_valid` in any state other than ACCUM is ignored and the value is dropped.
- Saturating addition:
  - Positive overflow clamps to +(2^(SUM_WIDTH-1) − 1) (32767 at defaults).
  - Negative overflow clamps to −2^(SUM_WIDTH-1) (−32768).
- DECIDE:
  - Compute pass = (acc ≥ threshold), as a signed compare.
  - Register `o_pass` and `o_sum`; go to DONE.
- DONE: `o_done`=1 for this single cycle; return to IDLE.
- `i_start` outside IDLE is ignored. There is no queuing and no restart.
- `reset` at any cycle, including mid-ACCUM:
  - Next state is IDLE.
  - Accumulator, counters, `o_ready`, `o_busy`, `o_done`, `o_pass` and `o_sum` all return to 0.
  - The partial stage is discarded.
- Reset values of all outputs are 0.

## Timing
- `i_start` accepted in cycle T → `o_busy`=1 and `o_ready`=1 from T+1.
- N values must each be accepted. Gaps in `i_valid` stall without penalty.
- Final value accepted in cycle Tk:
  - `o_ready`=0 from Tk+1 (DECIDE).
  - `o_done`=1, with `o_pass`/`o_sum` valid, in Tk+2.
  - `o_busy`=0 and `i_start` acceptable from Tk+3.
- Back-to-back rate: a stage of N values occupies N+3 cycles minimum (start, N accepts, DECIDE, DONE).
- Zero-count stage: start at T, DECIDE at T+1, `o_done` at T+2, pass = (0 ≥ threshold).
- `o_pass`/`o_sum` change only at DECIDE→DONE or on an accepted `i_start`/`reset`.

## Test plan
- Basic pass:
  - Stimulus: N=3, threshold=5; values 4, −1, 3 with `i_valid` continuous.
  - Required: `o_done` 2 cycles after the third accept; `o_sum`=6, `o_pass`=1; `o_busy` drops the following cycle.
- Fail with stalls:
  - Stimulus: N=2, threshold=0; values −3 and 2 separated by 4 idle cycles.
  - Required: accepts only when valid; `o_sum`=−1, `o_pass`=0; the dropped pre-start `i_valid` value 7 does not affect the sum.
- Saturation:
  - Stimulus: N=255, threshold=32767, every value 127.
  - Required: `o_sum`=32385, `o_pass`=0.
  - Repeat with SUM_WIDTH=12: `o_sum` clamps at 2047, `o_pass`=1 against threshold 2047.
- Zero-count stage:
  - Stimulus: N=0, threshold=0, then threshold=1.
  - Required: `o_done` at T+2, `o_ready` never high; `o_pass`=1, then `o_pass`=0; `o_sum`=0.
- Reset mid-stage:
  - Stimulus: N=4; assert `reset` for one cycle after 2 accepts, then start N=1, value 9, threshold 9.
  - Required: all outputs 0 the cycle after reset, no `o_done` for the aborted stage; the new stage yields `o_sum`=9, `o_pass`=1.
- Ignored start:
  - Stimulus: pulse `i_start` (N=1, threshold=−100) during ACCUM of a stage with N=2, threshold=10, values 6, 6.
  - Required: the latched parameters are unchanged; `o_sum`=12, `o_pass`=1; a single `o_done`.

Source files
------------

// File: rtl/haar_stage_accumulator.sv
// Per-stage accumulator for Haar cascade leaf values: saturating signed sum of
// N leaf values, signed compare against the stage threshold, registered verdict.
module haar_stage_accumulator #(
    parameter int DATA_WIDTH  = 8,
    parameter int SUM_WIDTH   = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic [COUNT_WIDTH-1:0]      i_num_classifiers,
    input  logic signed [SUM_WIDTH-1:0] i_stage_threshold,
    input  logic                        i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_haarvalue,
    output logic                        o_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_pass,
    output logic signed [SUM_WIDTH-1:0] o_sum
);

    localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    state;
    logic [COUNT_WIDTH-1:0]    num;
    logic [COUNT_WIDTH-1:0]    cnt;
    logic [COUNT_WIDTH-1:0]    cnt_next;
    logic signed [SUM_WIDTH-1:0] thr;
    logic signed [SUM_WIDTH-1:0] acc;
    logic signed [SUM_WIDTH-1:0] val_ext;
    logic [SUM_WIDTH:0]        wide;
    logic signed [SUM_WIDTH-1:0] sat_sum;

    // One guard bit: overflow shows up as the two top bits disagreeing,
    // and the guard bit carries the true sign of the unclamped result.
    always_comb begin
        val_ext  = SUM_WIDTH'(i_haarvalue);
        wide     = {acc[SUM_WIDTH-1], acc} + {val_ext[SUM_WIDTH-1], val_ext};
        sat_sum  = wide[SUM_WIDTH-1:0];
        if (wide[SUM_WIDTH] != wide[SUM_WIDTH-1])
            sat_sum = wide[SUM_WIDTH] ? SUM_MIN : SUM_MAX;
        cnt_next = cnt + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            num     <= '0;
            cnt     <= '0;
            thr     <= '0;
            acc     <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_pass  <= 1'b0;
            o_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        num    <= i_num_classifiers;
                        thr    <= i_stage_threshold;
                        acc    <= '0;
                        cnt    <= '0;
                        o_pass <= 1'b0;
                        o_sum  <= '0;
                        o_busy <= 1'b1;
                        // An empty stage skips accumulation and is judged on a zero sum.
                        if (i_num_classifiers != '0) begin
                            state   <= ACCUM;
                            o_ready <= 1'b1;
                        end else begin
                            state <= DECIDE;
                        end
                    end
                end
                ACCUM: begin
                    if (i_valid) begin
                        acc <= sat_sum;
                        cnt <= cnt_next;
                        if (cnt_next == num) begin
                            state   <= DECIDE;
                            o_ready <= 1'b0;
                        end
                    end
                end
                DECIDE: begin
                    o_pass <= (acc >= thr);
                    o_sum  <= acc;
                    o_done <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
